start_screen_scanner: RTL and testbench
=======================================

// Module: start_screen_scanner
// PURPOSE
//  640x480@60 VGA scan engine. Generates sync timing, drives the linear pixel
//  address into the start-image ROM, and registers the returned 12-bit colour
//  together with delayed syncs. A frame-aligned mode FSM selects between the
//  start image and the live game pixel stream. Sits between the image ROM and
//  the VGA output pins.
// PARAMETERS
//  PIX_DIV   4    clk cycles per pixel tick (100 MHz clk -> 25 MHz pixels); >=2
//  H_ACTIVE  640  visible pixels per line
//  H_TOTAL   800  pixels per line (FP 16, sync 96, BP 48)
//  V_ACTIVE  480  visible lines per frame
//  V_TOTAL   525  lines per frame (FP 10, sync 2, BP 33)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  start_btn  in   1   1-clk pulse (debounced upstream): leave start screen
//  game_over  in   1   1-clk pulse: return to start screen
//  game_rgb   in   12  game-renderer colour for the current (h_pos,v_pos)
//  rom_data   in   12  start-image ROM output (combinational from rom_addr)
//  rom_addr   out  19  linear ROM address = v*640+h, 0..307199
//  h_pos      out  10  current pixel column, 0..799
//  v_pos      out  10  current line, 0..524
//  pix_tick   out  1   1-clk strobe, high once per PIX_DIV clks
//  in_game    out  1   1 = game pixels selected, 0 = start image selected
//  vga_rgb    out  12  registered colour {R[3:0],G[3:0],B[3:0]}
//  vga_hs     out  1   horizontal sync, active low
//  vga_vs     out  1   vertical sync, active low
// BEHAVIOUR
//  Reset (async assert, sync release): divider=0, h_pos=0, v_pos=0,
//   rom_addr=0, pix_tick=0, in_game=0, vga_rgb=12'h000, vga_hs=1, vga_vs=1,
//   FSM=START, pending request flags cleared.
//  Divider: counts 0..PIX_DIV-1; pix_tick=1 in the clk where it equals
//   PIX_DIV-1. All other state below advances only on pix_tick.
//  Counters: h_pos increments; at 799 wraps to 0 and v_pos increments;
//   v_pos at 524 with h_pos at 799 wraps to 0.
//  Active region: h_pos<640 && v_pos<480.
//  rom_addr: increments by 1 on each pix_tick in the active region; reset to 0
//   on the tick that wraps (799,524)->(0,0). Always equals v*640+h inside the
//   active region and holds 307199+1 clamp-free: it stops at 307200 outside,
//   and is never presented above 307199 while active. No multiplier.
//  Pipeline (latency 1 pixel tick): on pix_tick, register
//   vga_rgb = active ? (in_game ? game_rgb : rom_data) : 12'h000;
//   vga_hs  = !(h_pos in 656..751); vga_vs = !(v_pos in 490..491).
//   Syncs and colour therefore stay mutually aligned.
//  Mode FSM: START, GAME.
//   START: start_btn sets req_go. On the pix_tick that wraps to (0,0) with
//    req_go=1 -> GAME, in_game=1, req_go cleared.
//   GAME: game_over sets req_stop; switch to START at the next frame wrap,
//    in_game=0, req_stop cleared.
//   Requests latched in any clk (not only on pix_tick); a pulse in the frame-
//   wrap clk itself takes effect at the following wrap. start_btn in GAME and
//   game_over in START are ignored. Both pulses in one clk: only the one valid
//   for the current state is latched.
//  Mode never changes mid-frame: no torn frames.
//  Reset mid-frame: all outputs return immediately to reset values; scanning
//   restarts at (0,0) in START.
// TESTING
//  1 Reset release, PIX_DIV=4: pix_tick every 4th clk; first frame wrap after
//    800*525=420000 ticks; vga_hs low for 96 ticks/line, vga_vs low 2 lines.
//  2 ROM model rom[i]=i[11:0]: at (h=5,v=2) rom_addr=1285; one tick later
//    vga_rgb=12'h505; at (h=639,v=479) rom_addr=307199; at h=640 rgb=000.
//  3 start_btn pulse at (h=100,v=200): in_game stays 0 to end of frame, goes
//    1 at wrap to (0,0); first GAME pixel vga_rgb equals game_rgb=12'hABC.
//  4 game_over pulse in GAME at v=10: in_game drops at next wrap; start_btn
//    pulses during GAME produce no mode change.
//  5 start_btn and game_over same clk in START: enters GAME at next wrap.
//  6 rst asserted at (h=300,v=300) for 3 clks: outputs at reset values
//    within that clk; after release counting restarts at (0,0), rom_addr=0.

Source files
------------

// File: rtl/start_screen_scanner.sv
// start_screen_scanner: VGA scan engine muxing the start-image ROM or the live game pixels onto the output pins.
// Latency: colour, hsync and vsync are registered together, one pixel tick after their (h_pos, v_pos).
// Backpressure: none. The scan free-runs, and mode requests are held until the next frame wrap.
module start_screen_scanner #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        game_over,
  input  logic [11:0] game_rgb,
  input  logic [11:0] rom_data,
  output logic [18:0] rom_addr,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic        pix_tick,
  output logic        in_game,
  output logic [11:0] vga_rgb,
  output logic        vga_hs,
  output logic        vga_vs
);

  // rst is expected to come from an upstream synchroniser, so its release is already clean.
  localparam int DW = $clog2(PIX_DIV);

  localparam logic [0:0] ST_START = 1'b0;
  localparam logic [0:0] ST_GAME  = 1'b1;

  logic [DW-1:0] div;
  logic [0:0]    state;
  logic          req_go;
  logic          req_stop;
  logic          active;
  logic          h_last;
  logic          v_last;
  logic          wrap;
  logic          hs_n;
  logic          vs_n;

  // pix_tick is decoded from the divider register, so it never goes high while rst is asserted.
  assign pix_tick = (div == DW'(PIX_DIV - 1));
  assign h_last   = (h_pos == 10'(H_TOTAL - 1));
  assign v_last   = (v_pos == 10'(V_TOTAL - 1));
  assign wrap     = pix_tick && h_last && v_last;
  assign active   = (h_pos < 10'(H_ACTIVE)) && (v_pos < 10'(V_ACTIVE));
  assign hs_n     = !((h_pos >= 10'(H_ACTIVE + H_FP)) && (h_pos < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n     = !((v_pos >= 10'(V_ACTIVE + V_FP)) && (v_pos < 10'(V_ACTIVE + V_FP + V_SYNC)));
  assign in_game  = (state == ST_GAME);

  // Pixel clock divider: free-running modulo-PIX_DIV count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Raster counters: the column advances on every pixel tick, and the line advances at the end of each line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_pos <= '0;
      v_pos <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h_pos <= '0;
        v_pos <= v_last ? 10'd0 : v_pos + 10'd1;
      end else begin
        h_pos <= h_pos + 10'd1;
      end
    end
  end

  // ROM address: one increment per visible pixel avoids a v*width multiply.
  // The address parks at the next line start during blanking and at the image size after the last line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
    end else if (pix_tick) begin
      if (wrap) begin
        rom_addr <= '0;
      end else if (active) begin
        rom_addr <= rom_addr + 19'd1;
      end
    end
  end

  // Output stage: colour and syncs are registered on the same tick, so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_rgb <= 12'h000;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
    end else if (pix_tick) begin
      vga_rgb <= active ? (in_game ? game_rgb : rom_data) : 12'h000;
      vga_hs  <= hs_n;
      vga_vs  <= vs_n;
    end
  end

  // Mode FSM: requests latch in any clk and take effect only at a frame wrap, so frames are never torn.
  // A request seen in the wrap clk itself waits for the following wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_START;
      req_go   <= 1'b0;
      req_stop <= 1'b0;
    end else if (state == ST_START) begin
      if (wrap && req_go) begin
        state  <= ST_GAME;
        req_go <= 1'b0;
      end else if (start_btn) begin
        req_go <= 1'b1;
      end
    end else begin
      if (wrap && req_stop) begin
        state    <= ST_START;
        req_stop <= 1'b0;
      end else if (game_over) begin
        req_stop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_start_screen_scanner.sv
// tb_start_screen_scanner: directed bench for start_screen_scanner, using a reduced raster so whole frames run quickly.
// A reference model tracks the divider, counters and mode; expected colour/syncs go through a scoreboard queue.
// Inputs are driven 1 time unit after posedge, and outputs are sampled 1 time unit after the next posedge.
module tb_start_screen_scanner;

  localparam int PD  = 4;
  localparam int HA  = 20;
  localparam int HT  = 28;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int VA  = 6;
  localparam int VT  = 10;
  localparam int VFP = 1;
  localparam int VS  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0;
  logic        game_over = 1'b0;
  logic [11:0] game_rgb = 12'hABC;
  logic [11:0] rom_data;
  logic [18:0] rom_addr;
  logic [9:0]  h_pos;
  logic [9:0]  v_pos;
  logic        pix_tick;
  logic        in_game;
  logic [11:0] vga_rgb;
  logic        vga_hs;
  logic        vga_vs;

  // ROM model: rom[i] = i[11:0], combinational from the address.
  assign rom_data = rom_addr[11:0];

  start_screen_scanner #(
    .PIX_DIV(PD), .H_ACTIVE(HA), .H_TOTAL(HT), .H_FP(HFP), .H_SYNC(HS),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_FP(VFP), .V_SYNC(VS)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .game_over(game_over),
    .game_rgb(game_rgb), .rom_data(rom_data), .rom_addr(rom_addr),
    .h_pos(h_pos), .v_pos(v_pos), .pix_tick(pix_tick), .in_game(in_game),
    .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mdiv, mh, mv;
  logic mmode, mreq;
  logic [13:0] sbq[$];
  logic [11:0] cur_rgb;
  logic cur_hs, cur_vs;
  int hs_lo, vs_lo;

  function automatic int addr_model(input int h, input int v);
    if (v >= VA) return VA * HA;
    if (h >= HA) return (v + 1) * HA;
    return v * HA + h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (h=%0d v=%0d t=%0t)", tag, obs, exp, mh, mv, $time);
    end
  endtask

  task automatic model_reset();
    mdiv = 0; mh = 0; mv = 0; mmode = 1'b0; mreq = 1'b0;
    sbq.delete();
    cur_rgb = 12'h000; cur_hs = 1'b1; cur_vs = 1'b1;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_h_pos"},    32'(h_pos),    0);
    chk({tag, "_v_pos"},    32'(v_pos),    0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_pix_tick"}, 32'(pix_tick), 0);
    chk({tag, "_in_game"},  32'(in_game),  0);
    chk({tag, "_vga_rgb"},  32'(vga_rgb),  0);
    chk({tag, "_vga_hs"},   32'(vga_hs),   1);
    chk({tag, "_vga_vs"},   32'(vga_vs),   1);
  endtask

  // One clk: drive inputs, advance the model, let the edge pass, then compare all outputs.
  task automatic cyc(input logic sb, input logic go);
    logic tick, wrap, act;
    logic [13:0] e;
    start_btn = sb;
    game_over = go;
    tick = (mdiv == PD - 1);
    wrap = tick && (mh == HT - 1) && (mv == VT - 1);
    if (tick) begin
      act = (mh < HA) && (mv < VA);
      e[13:2] = act ? (mmode ? game_rgb : 12'(addr_model(mh, mv))) : 12'h000;
      e[1] = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
      e[0] = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
      sbq.push_back(e);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    mdiv = tick ? 0 : mdiv + 1;
    if (!mmode) begin
      if (wrap && mreq) begin mmode = 1'b1; mreq = 1'b0; end
      else if (sb) mreq = 1'b1;
    end else begin
      if (wrap && mreq) begin mmode = 1'b0; mreq = 1'b0; end
      else if (go) mreq = 1'b1;
    end
    @(posedge clk);
    #1;
    start_btn = 1'b0;
    game_over = 1'b0;
    if (tick) begin
      e = sbq.pop_front();
      cur_rgb = e[13:2];
      cur_hs = e[1];
      cur_vs = e[0];
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
    end
    chk("h_pos",    32'(h_pos),    32'(mh));
    chk("v_pos",    32'(v_pos),    32'(mv));
    chk("rom_addr", 32'(rom_addr), 32'(addr_model(mh, mv)));
    chk("pix_tick", 32'(pix_tick), 32'(mdiv == PD - 1));
    chk("in_game",  32'(in_game),  32'(mmode));
    chk("vga_rgb",  32'(vga_rgb),  32'(cur_rgb));
    chk("vga_hs",   32'(vga_hs),   32'(cur_hs));
    chk("vga_vs",   32'(vga_vs),   32'(cur_vs));
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    while (k < n) begin
      if (mdiv == PD - 1) k++;
      cyc(1'b0, 1'b0);
    end
  endtask

  // Run until the tick that lands on (h, v). The loop is bounded by two frames.
  task automatic run_to(input int h, input int v);
    int n = 0;
    do begin
      cyc(1'b0, 1'b0);
      n++;
    end while (!(mdiv == 0 && mh == h && mv == v) && n < 2 * HT * VT * PD);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    reset_check("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Timing: first frame after release; sync-low counts over one full frame.
    hs_lo = 0; vs_lo = 0;
    run_ticks(HT * VT);
    chk("frame_wrap_pos", 32'({v_pos, h_pos}), 0);
    chk("hs_low_ticks", 32'(hs_lo), HS * VT);
    chk("vs_low_ticks", 32'(vs_lo), VS * HT);

    // ROM addressing and the one-tick colour latency.
    run_to(5, 2);
    chk("addr_5_2", 32'(rom_addr), 2 * HA + 5);
    run_ticks(1);
    chk("rgb_5_2", 32'(vga_rgb), 32'h02D);
    run_to(HA - 1, VA - 1);
    chk("addr_last", 32'(rom_addr), VA * HA - 1);
    run_ticks(1);
    chk("rgb_last", 32'(vga_rgb), 32'h077);
    run_ticks(1);
    chk("rgb_h_active", 32'(vga_rgb), 0);

    // start_btn mid-frame: the mode changes only at the wrap.
    run_to(10, 3);
    cyc(1'b1, 1'b0);
    run_to(HT - 1, VT - 1);
    chk("go_before_wrap", 32'(in_game), 0);
    run_to(0, 0);
    chk("go_at_wrap", 32'(in_game), 1);
    run_ticks(1);
    chk("first_game_px", 32'(vga_rgb), 32'hABC);

    // game_over returns to START at the next wrap; start_btn in GAME is ignored.
    run_to(0, 2);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    run_to(HT - 1, VT - 1);
    chk("stop_before_wrap", 32'(in_game), 1);
    run_to(0, 0);
    chk("stop_at_wrap", 32'(in_game), 0);
    run_to(0, 0);
    chk("btn_in_game_ignored", 32'(in_game), 0);

    // Both pulses in the same clk while in START.
    run_to(5, 1);
    cyc(1'b1, 1'b1);
    run_to(0, 0);
    chk("both_pulses", 32'(in_game), 1);

    // Mid-frame reset while in GAME.
    run_to(15, 4);
    rst = 1'b1;
    #1;
    reset_check("rst_imm");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_check("rst_hold");
    rst = 1'b0;
    repeat (PD) cyc(1'b0, 1'b0);
    chk("restart_h", 32'(h_pos), 1);
    chk("restart_addr", 32'(rom_addr), 1);

    // start_btn in the wrap clk itself waits for the following wrap.
    run_to(HT - 1, VT - 1);
    while (mdiv != PD - 1) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("wrap_pulse_defer", 32'(in_game), 0);
    run_to(0, 0);
    chk("wrap_pulse_next", 32'(in_game), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
